// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared state encodings, reset pointer and mod-4 rotate helper
package riscv_arb_pkg;

  localparam logic       ST_EMPTY  = 1'b0;
  localparam logic       ST_FULL   = 1'b1;
  localparam logic [1:0] RESET_PTR = 2'd3;

  typedef enum logic {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL
  } arb_state_e;

  function automatic logic [1:0] rot4(input logic [1:0] base, input logic [1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - requester/downstream bundle; lock exists only with MUX4_RR_ARBITER_LOCK_EN
interface mux4_rr_arbiter_if #(parameter int WIDTH = 64);

  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
`ifdef MUX4_RR_ARBITER_LOCK_EN
  logic             lock;

  modport master (
    output req, d0, d1, d2, d3, out_ready, lock,
    input  grant, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready, lock,
    output grant, sel, out_valid, out_data, out_src
  );
`else
  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  grant, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output grant, sel, out_valid, out_data, out_src
  );
`endif

endinterface

// File: rtl/mux4.sv
// rtl/mux4.sv - shared WIDTH-bit 4:1 result mux
module mux4 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter_pick.sv
// rtl/mux4_rr_arbiter_pick.sv - rr_pick4: search from last_ptr+1 with wrap, first set request wins
module rr_pick4
  import riscv_arb_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_last_ptr,
  output logic [1:0] o_idx,
  output logic       o_any
);

  logic [1:0] w_start;
  logic [1:0] w_cand;

  assign w_start = rot4(i_last_ptr, 2'd1);
  assign o_any   = |i_req;

  // Walk from the far end so the candidate closest to w_start overwrites last.
  always_comb begin
    o_idx  = i_last_ptr;
    w_cand = w_start;
    for (int k = 3; k >= 0; k--) begin
      w_cand = rot4(w_start, 2'(k));
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin 4:1 mux sequencer with one-entry output register
// Optional burst lock under MUX4_RR_ARBITER_LOCK_EN.
module mux4_rr_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  mux4_rr_arbiter_if.slave bus
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [1:0]       r_last_ptr;
  logic [1:0]       w_last_ptr_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_src;
  logic [1:0]       w_idx;
  logic             w_any;
  logic             w_can_load;
  logic             w_load;
  logic [3:0]       w_grant;
  logic [WIDTH-1:0] w_mux_y;

  rr_pick4 u_pick (
    .i_req      (bus.req),
    .i_last_ptr (r_last_ptr),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  assign bus.sel = w_any ? w_idx : r_last_ptr;

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .sel (bus.sel),
    .y   (w_mux_y)
  );

`ifdef MUX4_RR_ARBITER_LOCK_EN
  assign w_last_ptr_nxt = bus.lock ? rot4(w_idx, 2'd3) : w_idx;
`else
  assign w_last_ptr_nxt = w_idx;
`endif

  // rst_n gates the load so grant is quiet while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 4'b0000;
    w_can_load  = (r_state == S_EMPTY) || bus.out_ready;
    w_load      = w_can_load && w_any && rst_n;
    if (w_load) begin
      w_state_nxt    = S_FULL;
      w_grant[w_idx] = 1'b1;
    end else if ((r_state == S_FULL) && bus.out_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_src  <= 2'd0;
      r_last_ptr <= RESET_PTR;
    end else if (w_load) begin
      r_out_data <= w_mux_y;
      r_out_src  <= w_idx;
      r_last_ptr <= w_last_ptr_nxt;
    end
  end

  assign bus.grant     = w_grant;
  assign bus.out_valid = (r_state == S_FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule
